// File: rtl/apu_write_scheduler.sv
// Register-write scheduler in front of the APU register file: frame tick generation,
// a post-tick sequencer window, and a small host FIFO drained whenever the sequencer is idle.
module apu_write_scheduler #(
    parameter int CLKRATE    = 1_789_773,
    parameter int FRAMERATE  = 60,
    parameter int SEQ_WINDOW = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_data,
    input  logic                          seq_valid,
    output logic                          seq_ready,
    input  logic [ADDR_W-1:0]             seq_addr,
    input  logic [DATA_W-1:0]             seq_data,
    output logic                          frame_tick,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int FRAME_DIV = CLKRATE / FRAMERATE;
    localparam int FCNT_W    = $clog2(FRAME_DIV);
    localparam int WCNT_W    = $clog2(SEQ_WINDOW + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SEQ,
        GNT_HOST
    } grant_e;

    logic [FCNT_W-1:0]        frame_cnt;
    logic [WCNT_W-1:0]        win_cnt;
    logic                     in_window;

    logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LVL_W-1:0]         count;
    logic                     push;
    logic                     pop;
    grant_e                   grant;

    // The tick rises as the counter wraps, so the first tick lands FRAME_DIV cycles after release.
    // NOTE: every register below uses non-blocking assignment so all state updates on the
    // same edge see pre-edge values, regardless of statement order between processes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b1;
        end else begin
            frame_cnt  <= frame_cnt + FCNT_W'(1);
            frame_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (frame_tick) begin
            win_cnt <= WCNT_W'(SEQ_WINDOW);
        end else if (win_cnt != '0) begin
            win_cnt <= win_cnt - WCNT_W'(1);
        end
    end

    assign in_window  = (win_cnt != '0);
    assign seq_ready  = in_window;
    assign host_ready = (count != LVL_W'(FIFO_DEPTH));
    assign fifo_level = count;
    assign push       = host_valid & host_ready;
    assign pop        = (grant == GNT_HOST);

    // NOTE: defaults first so every path assigns grant and no latch is inferred.
    always_comb begin
        grant = GNT_NONE;
        if (in_window && seq_valid) begin
            grant = GNT_SEQ;
        end else if (count != '0) begin
            grant = GNT_HOST;
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and count is what
    // discards stale entries, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {host_addr, host_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Address/data only move on a grant, so they hold between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= (grant != GNT_NONE);
            case (grant)
                GNT_SEQ: begin
                    wr_addr <= seq_addr;
                    wr_data <= seq_data;
                end
                GNT_HOST: begin
                    {wr_addr, wr_data} <= mem[rd_ptr];
                end
                default: begin
                    wr_addr <= wr_addr;
                    wr_data <= wr_data;
                end
            endcase
        end
    end

endmodule
